// File: rtl/temp_mon_pkg.sv
// Shared types and default parameters for the temperature monitor.
package temp_mon_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StNormal,
        StPendHi,
        StAlarm,
        StPendLo
    } state_e;

    localparam int unsigned DefDataW    = 4;
    localparam int unsigned DefHiThresh = 12;
    localparam int unsigned DefLoThresh = 4;
    localparam int unsigned DefDebounce = 3;
    localparam int unsigned DefCntW     = 8;

endpackage

// File: rtl/minmax_tracker.sv
// Running min/max/count statistics over accepted samples.
module minmax_tracker #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              seen_o
);

    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              seen_q, seen_d;

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (valid_i) begin
            if (!seen_q || data_i < min_q) min_d = data_i;
            if (!seen_q || data_i > max_q) max_d = data_i;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            min_q  <= '1;
            max_q  <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign min_o  = min_q;
    assign max_o  = max_q;
    assign cnt_o  = cnt_q;
    assign seen_o = seen_q;

endmodule

// File: rtl/temp_monitor.sv
// Sample statistics plus a debounced hysteresis over-temperature alarm.
module temp_monitor
    import temp_mon_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned HI_THRESH = DefHiThresh,
    parameter int unsigned LO_THRESH = DefLoThresh,
    parameter int unsigned DEBOUNCE  = DefDebounce,
    parameter int unsigned CNT_W     = DefCntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              temp_valid,
    input  logic [DATA_W-1:0] temp,
    input  logic              clear,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              stat_valid,
    output logic              alarm,
    output logic              alarm_rise,
    output logic              alarm_fall
);

    localparam int unsigned       DbW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DbW-1:0]    DbLast = DbW'(DEBOUNCE - 1);
    localparam logic [DATA_W-1:0] HiLvl  = DATA_W'(HI_THRESH);
    localparam logic [DATA_W-1:0] LoLvl  = DATA_W'(LO_THRESH);

    state_e         state_q, state_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           alarm_q, alarm_d, rise_q, rise_d, fall_q, fall_d;
    logic           accept, is_hi, is_lo, run_done;

    assign accept = temp_valid & ~clear;
    assign is_hi  = temp >= HiLvl;
    assign is_lo  = temp <= LoLvl;
    // Counter is zero outside PEND states, so DEBOUNCE=1 completes on the first sample.
    assign run_done = db_cnt_q == DbLast;

    minmax_tracker #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_minmax (
        .clk_i  (clk),
        .rst_i  (rst),
        .clear_i(clear),
        .valid_i(accept),
        .data_i (temp),
        .min_o  (min_out),
        .max_o  (max_out),
        .cnt_o  (sample_cnt),
        .seen_o (stat_valid)
    );

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        if (accept) begin
            unique case (state_q)
                StIdle, StNormal, StPendHi: begin
                    if (!is_hi) begin
                        state_d  = StNormal;
                        db_cnt_d = '0;
                    end else if (run_done) begin
                        state_d  = StAlarm;
                        db_cnt_d = '0;
                    end else begin
                        state_d  = StPendHi;
                        db_cnt_d = db_cnt_q + DbW'(1);
                    end
                end
                StAlarm, StPendLo: begin
                    if (!is_lo) begin
                        state_d  = StAlarm;
                        db_cnt_d = '0;
                    end else if (run_done) begin
                        state_d  = StNormal;
                        db_cnt_d = '0;
                    end else begin
                        state_d  = StPendLo;
                        db_cnt_d = db_cnt_q + DbW'(1);
                    end
                end
                default: begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end
            endcase
        end
        alarm_d = (state_d == StAlarm) || (state_d == StPendLo);
        rise_d  = alarm_d && !alarm_q;
        fall_d  = (state_d == StNormal) && alarm_q;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q  <= StIdle;
            db_cnt_q <= '0;
            alarm_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            alarm_q  <= alarm_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign alarm_fall = fall_q;

endmodule

// File: doc/temp_monitor.md
Name: temp_monitor

Overview:
- Downstream consumer of the 4-bit `temp` sample stream that the top-level bench drives.
- Qualifies each sample and tracks running min, max and sample count.
- Raises a debounced over-threshold alarm through a hysteresis FSM.
- Sits between the stimulus/sample source and the console/scoreboard checks; all outputs are registered.

Parameters:
- DATA_W, 4, sample width in bits.
- HI_THRESH, 12, sample >= HI_THRESH counts toward alarm entry.
- LO_THRESH, 4, sample <= LO_THRESH counts toward alarm exit; must be < HI_THRESH.
- DEBOUNCE, 3, consecutive qualifying samples needed to enter or leave alarm (>=1).
- CNT_W, 8, sample counter width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- temp_valid  input  1  sample strobe; one sample per cycle when high.
- temp  input  DATA_W  sample value, unsigned.
- clear  input  1  synchronous statistics/FSM clear, same effect as rst.
- min_out  output  DATA_W  smallest sample since reset/clear.
- max_out  output  DATA_W  largest sample since reset/clear.
- sample_cnt  output  CNT_W  accepted samples, saturating.
- stat_valid  output  1  high once at least one sample has been accepted.
- alarm  output  1  debounced over-threshold level.
- alarm_rise  output  1  one-cycle pulse on alarm 0->1.
- alarm_fall  output  1  one-cycle pulse on alarm 1->0.

Behaviour:
- Reset/clear values: min_out = all-ones, max_out = 0, sample_cnt = 0, stat_valid = 0, alarm = 0, pulses = 0, FSM = IDLE, debounce counter = 0.
- Priority: rst > clear > temp_valid. A sample presented in a clear cycle is dropped.
- Latency: a sample accepted at edge N is reflected in all outputs after edge N (visible in cycle N+1).
- Statistics:
  - min_out = min(min_out, temp); max_out = max(max_out, temp).
  - The first accepted sample loads both min_out and max_out.
  - sample_cnt += 1, saturating at 2^CNT_W-1 with no wrap.
  - stat_valid sets on the first accepted sample.
- temp_valid = 0: no state change; pulses deassert.
- FSM states:
  - IDLE: no sample yet. Any accepted sample goes to NORMAL, or to PEND_HI if temp >= HI_THRESH (debounce cnt = 1).
  - NORMAL: on temp >= HI_THRESH go to PEND_HI, cnt = 1.
  - PEND_HI:
    - temp >= HI_THRESH: cnt += 1; when cnt reaches DEBOUNCE go to ALARM.
    - Otherwise go back to NORMAL, cnt = 0.
  - ALARM: on temp <= LO_THRESH go to PEND_LO, cnt = 1.
  - PEND_LO:
    - temp <= LO_THRESH: cnt += 1; when cnt reaches DEBOUNCE go to NORMAL.
    - Otherwise go back to ALARM, cnt = 0.
  - DEBOUNCE = 1: entry/exit is immediate (IDLE/NORMAL -> ALARM, ALARM -> NORMAL) without visiting PEND states.
- alarm = 1 in ALARM and PEND_LO; 0 elsewhere.
- Edge pulses:
  - alarm_rise is high for exactly the one cycle after the transition into ALARM from a non-alarm state.
  - alarm_fall is high for exactly the one cycle after the transition into NORMAL from PEND_LO/ALARM.
- Samples strictly between LO_THRESH and HI_THRESH hold the alarm state (hysteresis band) but reset any pending count.
- Non-consecutive gaps (temp_valid = 0) do not break a debounce run; only a non-qualifying sample does.
- rst or clear mid-alarm: alarm drops to 0 next cycle; alarm_fall is NOT pulsed.

Decomposition:
- Package temp_mon_pkg:
  - state enum typedef {IDLE, NORMAL, PEND_HI, ALARM, PEND_LO}.
  - Default threshold/debounce localparams.
- Sub-module minmax_tracker: holds the min/max/count/stat_valid registers.
- The FSM and debounce counter stay in temp_monitor.

Test Plan:
- Reset then samples 4, 12, 3 -> min_out 3, max_out 12, sample_cnt 3, stat_valid 1, alarm 0.
- Samples 12, 13, 15 -> alarm rises in the cycle after the third sample; alarm_rise pulses exactly once.
- Samples 12, 13, 7, 12 -> no alarm (run broken by 7); FSM ends in PEND_HI with cnt 1.
- In alarm, samples 3, 8, 2, 1, 0 -> run broken by 8; alarm falls after 0; alarm_fall pulses once.
- clear asserted with temp_valid = 1, temp = 9 while in alarm -> all outputs at reset values; sample dropped; no alarm_fall.
- CNT_W = 2, six samples -> sample_cnt saturates at 3.
